// File: rtl/im_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : im_loader_pkg
// Description : Shared types, constants and lane-mask helper for the IM loader.
// Revision    : 1.0 - initial release
// ============================================================================
package im_loader_pkg;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [3:0] WE_FULL        = 4'b1111;

    typedef enum logic [1:0] {
        ST_RECV  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    // Write-enable mask covering lanes 0..k of a word whose last byte sits in lane k.
    function automatic logic [3:0] lane_mask(input logic [1:0] k);
        logic [3:0] m;
        case (k)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            2'd2:    m = 4'b0111;
            default: m = WE_FULL;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/im_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : im_loader_if
// Description : Program byte stream (valid/ready with last) feeding the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface im_loader_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface
`default_nettype wire

// File: rtl/im_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : im_word_packer
// Description : Packs bytes little-endian into a 32-bit word; tracks byte lane.
// Revision    : 1.0 - initial release
// ============================================================================
module im_word_packer
    import im_loader_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_accept,
    input  wire logic        i_clear,
    input  wire logic [7:0]  i_data,
    output logic      [31:0] o_word_next,
    output logic      [1:0]  o_byte_cnt
);

    logic [31:0] word_q, word_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] w_word_ins;

    // Word as it would look with i_data inserted at the current lane.
    always_comb begin
        w_word_ins = word_q;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (byte_cnt_q == 2'(i)) begin
                w_word_ins[8*i +: 8] = i_data;
            end
        end
    end

    always_comb begin
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        if (i_clear) begin
            word_d     = '0;
            byte_cnt_d = '0;
        end else if (i_accept) begin
            word_d     = w_word_ins;
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
        end else begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign o_word_next = w_word_ins;
    assign o_byte_cnt  = byte_cnt_q;

endmodule
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module      : im_loader
// Description : Loads a byte-streamed program image into IM, holding the core
//               in reset until the final word has been written.
// Revision    : 1.0 - initial release
// ============================================================================
module im_loader
    import im_loader_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 16384
) (
    input  wire logic              clk,
    input  wire logic              rst,
    im_loader_if.slave             s_if,
    input  wire logic              load_req,
    output logic      [3:0]        im_w_en,
    output logic      [ADDR_W-1:0] im_address,
    output logic      [31:0]       im_write_data,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   err,
    output logic      [14:0]       word_count
);

    localparam logic [14:0] C_MAX_IDX = 15'(MAX_WORDS);

    state_e              state_q, state_d;
    logic [14:0]         word_idx_q, word_idx_d;
    logic                last_q, last_d;
    logic [3:0]          im_w_en_q, im_w_en_d;
    logic [ADDR_W-1:0]   im_address_q, im_address_d;
    logic [31:0]         im_write_data_q, im_write_data_d;

    logic                w_pack_accept;
    logic                w_pack_clear;
    logic [31:0]         w_pack_next;
    logic [1:0]          w_byte_cnt;

    im_word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_accept    (w_pack_accept),
        .i_clear     (w_pack_clear),
        .i_data      (s_if.s_data),
        .o_word_next (w_pack_next),
        .o_byte_cnt  (w_byte_cnt)
    );

    // IM port values are registered on the completing byte so the write
    // shows up during WRITE and then holds after the enable drops.
    always_comb begin
        state_d         = state_q;
        word_idx_d      = word_idx_q;
        last_d          = last_q;
        im_w_en_d       = 4'b0000;
        im_address_d    = im_address_q;
        im_write_data_d = im_write_data_q;
        w_pack_accept   = 1'b0;
        w_pack_clear    = 1'b0;

        case (state_q)
            ST_RECV: begin
                if (s_if.s_valid) begin
                    if (word_idx_q == C_MAX_IDX) begin
                        state_d = ST_ERR;
                    end else begin
                        w_pack_accept = 1'b1;
                        if (w_byte_cnt == 2'd3 || s_if.s_last) begin
                            state_d         = ST_WRITE;
                            last_d          = s_if.s_last;
                            im_w_en_d       = lane_mask(w_byte_cnt);
                            im_address_d    = BASE_ADDR + ADDR_W'({word_idx_q, 2'b00});
                            im_write_data_d = w_pack_next;
                        end
                    end
                end
            end
            ST_WRITE: begin
                word_idx_d   = word_idx_q + 15'd1;
                w_pack_clear = 1'b1;
                last_d       = 1'b0;
                state_d      = last_q ? ST_DONE : ST_RECV;
            end
            ST_DONE, ST_ERR: begin
                if (load_req) begin
                    state_d      = ST_RECV;
                    word_idx_d   = '0;
                    w_pack_clear = 1'b1;
                end
            end
            default: state_d = ST_RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ST_RECV;
            word_idx_q      <= '0;
            last_q          <= 1'b0;
            im_w_en_q       <= 4'b0000;
            im_address_q    <= BASE_ADDR;
            im_write_data_q <= '0;
        end else begin
            state_q         <= state_d;
            word_idx_q      <= word_idx_d;
            last_q          <= last_d;
            im_w_en_q       <= im_w_en_d;
            im_address_q    <= im_address_d;
            im_write_data_q <= im_write_data_d;
        end
    end

    assign s_if.s_ready  = (state_q == ST_RECV);
    assign cpu_hold      = (state_q != ST_DONE);
    assign done          = (state_q == ST_DONE);
    assign err           = (state_q == ST_ERR);
    assign word_count    = word_idx_q;
    assign im_w_en       = im_w_en_q;
    assign im_address    = im_address_q;
    assign im_write_data = im_write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_im_loader
// Description : Self-checking bench for im_loader with an IM SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_loader;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        int          gap;
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic [31:0] exp_data;
        logic [3:0]  exp_we;
    } vec_t;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  we;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic [3:0]  im_w_en;
    logic [15:0] im_address;
    logic [31:0] im_write_data;
    logic        cpu_hold, done, err;
    logic [14:0] word_count;

    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    bit   ok;
    vec_t vecs[$];
    wr_t  sb[$];
    wr_t  mon_e;
    logic [31:0] mem [0:15];

    im_loader_if s_if ();

    im_loader #(
        .ADDR_W    (16),
        .BASE_ADDR (16'h0000),
        .MAX_WORDS (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_if          (s_if),
        .load_req      (load_req),
        .im_w_en       (im_w_en),
        .im_address    (im_address),
        .im_write_data (im_write_data),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .err           (err),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (im_w_en[i]) mem[im_address[5:2]][8*i +: 8] <= im_write_data[8*i +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Every IM write must match the oldest expected write.
    always @(negedge clk) begin
        if (mon_en && im_w_en !== 4'b0000) begin
            if (sb.size() == 0) begin
                chk("sb_extra_write", {16'h0, im_address}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_addr", {16'h0, im_address}, {16'h0, mon_e.a});
                chk("sb_data", im_write_data, mon_e.d);
                chk("sb_we", {28'h0, im_w_en}, {28'h0, mon_e.we});
            end
        end
    end

    function automatic vec_t mk(logic [7:0] d, logic l, int g, logic w,
                                logic [15:0] a, logic [31:0] dat, logic [3:0] we);
        vec_t v;
        v.data = d; v.last = l; v.gap = g; v.exp_wr = w;
        v.exp_addr = a; v.exp_data = dat; v.exp_we = we;
        return v;
    endfunction

    task automatic send(input logic [7:0] d, input logic l);
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        s_if.s_last  = l;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (s_if.s_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        s_if.s_data  = 8'($urandom);
        if (!ok) chk("send_timeout", 32'h0, 32'h1);
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            if (vecs[i].gap > 0) begin
                repeat (vecs[i].gap) @(posedge clk);
                #1;
            end
            if (vecs[i].exp_wr) sb.push_back({vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_we});
            send(vecs[i].data, vecs[i].last);
            if (vecs[i].exp_wr) begin
                chk("vec_we", {28'h0, im_w_en}, {28'h0, vecs[i].exp_we});
                chk("vec_addr", {16'h0, im_address}, {16'h0, vecs[i].exp_addr});
                chk("vec_data", im_write_data, vecs[i].exp_data);
            end else begin
                chk("vec_no_write", {28'h0, im_w_en}, 32'h0);
            end
        end
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        chk("reload_done", {31'h0, done}, 32'h0);
        chk("reload_hold", {31'h0, cpu_hold}, 32'h1);
        chk("reload_err", {31'h0, err}, 32'h0);
        chk("reload_ready", {31'h0, s_if.s_ready}, 32'h1);
        chk("reload_wcnt", {17'h0, word_count}, 32'h0);
    endtask

    task automatic expect_done(input logic [14:0] wc);
        chk("pre_done", {31'h0, done}, 32'h0);
        chk("pre_hold", {31'h0, cpu_hold}, 32'h1);
        @(posedge clk);
        #1;
        chk("done", {31'h0, done}, 32'h1);
        chk("hold_released", {31'h0, cpu_hold}, 32'h0);
        chk("done_ready", {31'h0, s_if.s_ready}, 32'h0);
        chk("done_wcnt", {17'h0, word_count}, {17'h0, wc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; load_req = 1'b0;
        s_if.s_valid = 1'b0; s_if.s_last = 1'b0; s_if.s_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, s_if.s_ready}, 32'h1);
        chk("rst_hold", {31'h0, cpu_hold}, 32'h1);
        chk("rst_we", {28'h0, im_w_en}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_wcnt", {17'h0, word_count}, 32'h0);
        chk("rst_addr", {16'h0, im_address}, 32'h0);
        chk("rst_wdata", im_write_data, 32'h0);
        rst = 1'b1;
        mon_en = 1'b1;

        // Two full words, last on the eighth byte.
        vecs = '{mk(8'h13,0,0,0,0,0,0), mk(8'h05,0,0,0,0,0,0), mk(8'h00,0,0,0,0,0,0),
                 mk(8'h00,0,0,1,16'h0000,32'h0000_0513,4'b1111),
                 mk(8'h93,0,0,0,0,0,0), mk(8'h05,0,0,0,0,0,0), mk(8'h10,0,0,0,0,0,0),
                 mk(8'h00,1,0,1,16'h0004,32'h0010_0593,4'b1111)};
        run_vecs();
        expect_done(15'd2);
        chk("mem0_t1", mem[0], 32'h0000_0513);
        chk("mem1_t1", mem[1], 32'h0010_0593);
        pulse_load();

        // Partial final word: only lanes 0..1 written, upper lanes of mem[1] keep old bytes.
        vecs = '{mk(8'hAA,0,0,0,0,0,0), mk(8'hBB,0,0,0,0,0,0), mk(8'hCC,0,0,0,0,0,0),
                 mk(8'hDD,0,0,1,16'h0000,32'hDDCC_BBAA,4'b1111),
                 mk(8'h11,0,0,0,0,0,0),
                 mk(8'h22,1,0,1,16'h0004,32'h0000_2211,4'b0011)};
        run_vecs();
        expect_done(15'd2);
        chk("mem0_t2", mem[0], 32'hDDCC_BBAA);
        chk("mem1_t2", mem[1], 32'h0010_2211);
        pulse_load();

        // Same image as the first, with random idle gaps between bytes.
        vecs = '{mk(8'h13,0,1+$urandom_range(0,2),0,0,0,0), mk(8'h05,0,1+$urandom_range(0,2),0,0,0,0),
                 mk(8'h00,0,1+$urandom_range(0,2),0,0,0,0),
                 mk(8'h00,0,1+$urandom_range(0,2),1,16'h0000,32'h0000_0513,4'b1111),
                 mk(8'h93,0,1+$urandom_range(0,2),0,0,0,0), mk(8'h05,0,1+$urandom_range(0,2),0,0,0,0),
                 mk(8'h10,0,1+$urandom_range(0,2),0,0,0,0),
                 mk(8'h00,1,1+$urandom_range(0,2),1,16'h0004,32'h0010_0593,4'b1111)};
        run_vecs();
        expect_done(15'd2);
        chk("mem0_t3", mem[0], 32'h0000_0513);
        chk("mem1_t3", mem[1], 32'h0010_0593);
        chk("sb_empty_t3", sb.size(), 32'h0);
        pulse_load();

        // Overflow: MAX_WORDS=2, ninth byte is dropped and raises err.
        vecs = '{mk(8'h01,0,0,0,0,0,0), mk(8'h02,0,0,0,0,0,0), mk(8'h03,0,0,0,0,0,0),
                 mk(8'h04,0,0,1,16'h0000,32'h0403_0201,4'b1111),
                 mk(8'h05,0,0,0,0,0,0), mk(8'h06,0,0,0,0,0,0), mk(8'h07,0,0,0,0,0,0),
                 mk(8'h08,0,0,1,16'h0004,32'h0807_0605,4'b1111),
                 mk(8'h09,0,0,0,0,0,0)};
        run_vecs();
        chk("ovf_err", {31'h0, err}, 32'h1);
        chk("ovf_ready", {31'h0, s_if.s_ready}, 32'h0);
        chk("ovf_hold", {31'h0, cpu_hold}, 32'h1);
        chk("ovf_done", {31'h0, done}, 32'h0);
        chk("ovf_wcnt", {17'h0, word_count}, 32'h2);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_err_sticky", {31'h0, err}, 32'h1);
        pulse_load();

        // Reset after three bytes of the second word discards them.
        vecs = '{mk(8'hA0,0,0,0,0,0,0), mk(8'hA1,0,0,0,0,0,0), mk(8'hA2,0,0,0,0,0,0),
                 mk(8'hA3,0,0,1,16'h0000,32'hA3A2_A1A0,4'b1111),
                 mk(8'hB0,0,0,0,0,0,0), mk(8'hB1,0,0,0,0,0,0), mk(8'hB2,0,0,0,0,0,0)};
        run_vecs();
        chk("pre_rst_wcnt", {17'h0, word_count}, 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("midrst_we", {28'h0, im_w_en}, 32'h0);
        chk("midrst_wcnt", {17'h0, word_count}, 32'h0);
        chk("midrst_ready", {31'h0, s_if.s_ready}, 32'h1);
        chk("midrst_hold", {31'h0, cpu_hold}, 32'h1);
        vecs = '{mk(8'h01,0,1,0,0,0,0), mk(8'h02,0,0,0,0,0,0), mk(8'h03,0,0,0,0,0,0),
                 mk(8'h04,1,0,1,16'h0000,32'h0403_0201,4'b1111)};
        run_vecs();
        expect_done(15'd1);
        chk("mem0_t5", mem[0], 32'h0403_0201);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty_end", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
